// File: rtl/opfetch_pkg.sv
// rtl/opfetch_pkg.sv - shared widths and FSM state encoding for the operand fetch path
package opfetch_pkg;

    localparam int ROM_ADDR_W = 4;
    localparam int OP_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/op_fetch_sequencer_if.sv
// rtl/op_fetch_sequencer_if.sv - operand ROM bus plus operand-pair valid/ready handshake
interface op_fetch_sequencer_if
    import opfetch_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = OP_W
);

    logic              en_ROM;
    logic [ADDR_W-1:0] addr_ROM;
    logic [DATA_W-1:0] d_op1;
    logic [DATA_W-1:0] d_op2;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [ADDR_W-1:0] op_idx;

    modport master (
        output en_ROM, addr_ROM, op_valid, op1, op2, op_idx,
        input  d_op1, d_op2, op_ready
    );

    modport slave (
        input  en_ROM, addr_ROM, op_valid, op1, op2, op_idx,
        output d_op1, d_op2, op_ready
    );

endinterface

// File: rtl/op_fetch_sequencer_op_pair_reg.sv
// rtl/op_fetch_sequencer_op_pair_reg.sv - capture register for one operand pair and its source address
module op_pair_reg
    import opfetch_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d_op1,
    input  logic [DATA_W-1:0] d_op2,
    input  logic [ADDR_W-1:0] idx,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [ADDR_W-1:0] op_idx
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op1    <= '0;
            op2    <= '0;
            op_idx <= '0;
        end else if (load) begin
            op1    <= d_op1;
            op2    <= d_op2;
            op_idx <= idx;
        end
    end

endmodule

// File: rtl/op_fetch_sequencer.sv
// rtl/op_fetch_sequencer.sv - walks both operand ROMs and hands pairs to the ALU; OPFETCH_LOOP_EN selects continuous wrap
module op_fetch_sequencer
    import opfetch_pkg::*;
#(
    parameter int                ADDR_W    = ROM_ADDR_W,
    parameter int                DATA_W    = OP_W,
    parameter logic [ADDR_W-1:0] LAST_ADDR = '1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    op_fetch_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              load;
    logic              rom_en;
    logic              pair_valid;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [ADDR_W-1:0] op_idx_q;

`ifdef OPFETCH_LOOP_EN
    logic wrap_q;
    logic wrap_d;

    // done is reported during the FETCH that follows a wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign done = wrap_q;
`else
    assign done = (state_q == ST_DONE);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        load       = 1'b0;
        rom_en     = 1'b0;
        pair_valid = 1'b0;
`ifdef OPFETCH_LOOP_EN
        wrap_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                end
            end
            ST_FETCH: begin
                rom_en = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end else begin
                    load    = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                pair_valid = 1'b1;
                // abort beats a simultaneous handshake: the pair is treated as not consumed
                if (abort) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end else if (bus.op_ready) begin
                    if (addr_q == LAST_ADDR) begin
`ifdef OPFETCH_LOOP_EN
                        state_d = ST_FETCH;
                        addr_d  = '0;
                        wrap_d  = 1'b1;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_FETCH;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    op_pair_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pair (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .d_op1  (bus.d_op1),
        .d_op2  (bus.d_op2),
        .idx    (addr_q),
        .op1    (op1_q),
        .op2    (op2_q),
        .op_idx (op_idx_q)
    );

    assign bus.en_ROM   = rom_en;
    assign bus.addr_ROM = addr_q;
    assign bus.op_valid = pair_valid;
    assign bus.op1      = op1_q;
    assign bus.op2      = op2_q;
    assign bus.op_idx   = op_idx_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_op_fetch_sequencer.sv
// tb/tb_op_fetch_sequencer.sv - scoreboard bench for op_fetch_sequencer; OPFETCH_LOOP_EN selects the wrap scenario
module tb_op_fetch_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;
    logic busy;
    logic done;

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  idx;
    } pair_t;

    pair_t sb[$];

    localparam logic [31:0] ROM1 [16] = '{
        32'h0000_0004, 32'h0000_0011, 32'h0000_001E, 32'h0000_002B,
        32'h0000_0038, 32'h0000_003D, 32'h0000_0047, 32'h0000_0052,
        32'h0000_005A, 32'h0000_0060, 32'h0000_006B, 32'h0000_0071,
        32'h0000_007C, 32'h0000_0083, 32'h0000_0092, 32'h0000_0061
    };

    op_fetch_sequencer_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    op_fetch_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom2(input logic [3:0] a);
        return 32'h0000_0009 + {20'd0, a, 8'd0};
    endfunction

    // disabled ROMs return a marker so any sampling outside FETCH is visible
    assign bus.d_op1 = bus.en_ROM ? ROM1[bus.addr_ROM] : 32'hDEAD_BEEF;
    assign bus.d_op2 = bus.en_ROM ? rom2(bus.addr_ROM) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            pair_t p;
            p.idx = 4'(i);
            p.op1 = ROM1[i];
            p.op2 = rom2(4'(i));
            sb.push_back(p);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && bus.op_valid && bus.op_ready && !abort) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL sb_underflow: unexpected transfer idx=%0d", bus.op_idx);
            end else begin
                pair_t e;
                e = sb.pop_front();
                check("xfer_op1", 64'(bus.op1), 64'(e.op1));
                check("xfer_op2", 64'(bus.op2), 64'(e.op2));
                check("xfer_idx", 64'(bus.op_idx), 64'(e.idx));
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_present(input int idx);
        int n = 0;
        while (!(bus.op_valid && bus.op_idx == 4'(idx)) && n < 100) begin
            step;
            n++;
        end
        check("wait_present_timeout", 64'(n < 100), 64'(1));
    endtask

    task automatic wait_fetch(input int idx);
        int n = 0;
        while (!(bus.en_ROM && bus.addr_ROM == 4'(idx)) && n < 100) begin
            step;
            n++;
        end
        check("wait_fetch_timeout", 64'(n < 100), 64'(1));
    endtask

    task automatic run_until_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            step;
            n++;
        end
        check("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic kick;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    initial begin
        int n;
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        bus.op_ready = 1'b0;
        step;
        step;
        check("rst_en_ROM",   64'(bus.en_ROM),   64'(0));
        check("rst_op_valid", 64'(bus.op_valid), 64'(0));
        check("rst_busy",     64'(busy),         64'(0));
        check("rst_done",     64'(done),         64'(0));
        check("rst_op1",      64'(bus.op1),      64'(0));
        check("rst_op2",      64'(bus.op2),      64'(0));
        check("rst_op_idx",   64'(bus.op_idx),   64'(0));
        check("rst_addr_ROM", 64'(bus.addr_ROM), 64'(0));
        rst_n = 1'b1;
        step;

        bus.op_ready = 1'b1;
`ifdef OPFETCH_LOOP_EN
        push_range(0, 15);
        push_range(0, 15);
        push_range(0, 7);
`else
        push_range(0, 15);
`endif
        kick;
        check("c1_en_ROM",   64'(bus.en_ROM),   64'(1));
        check("c1_addr_ROM", 64'(bus.addr_ROM), 64'(0));
        check("c1_busy",     64'(busy),         64'(1));
        step;
        check("c2_op_valid", 64'(bus.op_valid), 64'(1));
        check("c2_op1",      64'(bus.op1),      64'h4);
        check("c2_op2",      64'(bus.op2),      64'h9);
        check("c2_op_idx",   64'(bus.op_idx),   64'(0));
        check("c2_en_ROM",   64'(bus.en_ROM),   64'(0));

`ifdef OPFETCH_LOOP_EN
        begin
            int nd = 0;
            int c1 = 0;
            int c2 = 0;
            int bl = 0;
            for (int c = 3; c <= 81; c++) begin
                step;
                if (done) begin
                    nd++;
                    if (nd == 1) c1 = c;
                    else if (nd == 2) c2 = c;
                end
                if (!busy) bl++;
            end
            check("loop_done_count", 64'(nd), 64'(2));
            check("loop_done_cyc1",  64'(c1), 64'(33));
            check("loop_done_cyc2",  64'(c2), 64'(65));
            check("loop_busy_low",   64'(bl), 64'(0));
            check("loop_sb_empty",   64'(sb.size()), 64'(0));
            check("loop_fetch_idx8", 64'(bus.addr_ROM), 64'(8));
            abort = 1'b1;
            step;
            abort = 1'b0;
            check("loop_abort_busy",  64'(busy),         64'(0));
            check("loop_abort_valid", 64'(bus.op_valid), 64'(0));
        end
`else
        run_until_done(n);
        check("pass_done_cycle", 64'(n), 64'(31));
        check("pass_busy_at_done", 64'(busy), 64'(1));
        step;
        check("pass_done_pulse", 64'(done), 64'(0));
        check("pass_busy_fall", 64'(busy), 64'(0));
        check("pass_done_count", 64'(done_cnt), 64'(1));
        check("pass_sb_empty", 64'(sb.size()), 64'(0));

        // back-pressure at idx 6
        push_range(0, 15);
        kick;
        wait_present(6);
        bus.op_ready = 1'b0;
        repeat (5) begin
            check("stall_valid",    64'(bus.op_valid), 64'(1));
            check("stall_op1",      64'(bus.op1),      64'h47);
            check("stall_idx",      64'(bus.op_idx),   64'(6));
            check("stall_en_ROM",   64'(bus.en_ROM),   64'(0));
            check("stall_addr_ROM", 64'(bus.addr_ROM), 64'(6));
            step;
        end
        bus.op_ready = 1'b1;
        step;
        check("stall_next_en",   64'(bus.en_ROM),   64'(1));
        check("stall_next_addr", 64'(bus.addr_ROM), 64'(7));
        run_until_done(n);
        step;
        check("stall_sb_empty", 64'(sb.size()), 64'(0));

        // abort colliding with a handshake at idx 3
        push_range(0, 2);
        kick;
        wait_present(3);
        d0 = done_cnt;
        abort = 1'b1;
        step;
        abort = 1'b0;
        check("abort_valid", 64'(bus.op_valid), 64'(0));
        check("abort_busy",  64'(busy),         64'(0));
        check("abort_addr",  64'(bus.addr_ROM), 64'(0));
        repeat (3) step;
        check("abort_no_done", 64'(done_cnt), 64'(d0));
        check("abort_sb_empty", 64'(sb.size()), 64'(0));
        push_range(0, 15);
        kick;
        check("restart_en",   64'(bus.en_ROM),   64'(1));
        check("restart_addr", 64'(bus.addr_ROM), 64'(0));
        run_until_done(n);
        step;
        check("restart_sb_empty", 64'(sb.size()), 64'(0));

        // reset during FETCH of idx 10 with a stray start
        push_range(0, 9);
        kick;
        wait_fetch(10);
        rst_n = 1'b0;
        start = 1'b1;
        step;
        check("mid_rst_en_ROM",   64'(bus.en_ROM),   64'(0));
        check("mid_rst_op_valid", 64'(bus.op_valid), 64'(0));
        check("mid_rst_busy",     64'(busy),         64'(0));
        check("mid_rst_done",     64'(done),         64'(0));
        check("mid_rst_op1",      64'(bus.op1),      64'(0));
        check("mid_rst_op2",      64'(bus.op2),      64'(0));
        check("mid_rst_op_idx",   64'(bus.op_idx),   64'(0));
        check("mid_rst_addr_ROM", 64'(bus.addr_ROM), 64'(0));
        rst_n = 1'b1;
        start = 1'b0;
        step;
        check("post_rst_idle", 64'(busy), 64'(0));
        check("post_rst_sb_empty", 64'(sb.size()), 64'(0));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
